// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one word per PC over req/ack, holds it
// for the decoder and strobes pc's inc on every accepted instruction.
//
// Ports:
//   clk, clr            clock, asynchronous active-low reset
//   pc_val              current PC from pc
//   Disable, flush      fetch stall, redirect (discard in-flight/held)
//   mem_req, mem_addr   instruction memory read request and address
//   mem_ack, mem_rdata  one-cycle read acknowledge and data
//   instr, instr_valid  fetched instruction to decoder
//   instr_ready         decoder accepts instr
//   inc                 combinational increment strobe to pc
//   fetch_err           sticky fault (misaligned PC or memory timeout)
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] pc_val,
    input  logic              Disable,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              inc,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        ERR
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t            state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              fetch_err_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              tmo;
    logic              hs;

    // Saturating wait counter; tmo flags the wait cycle that reaches
    // TIMEOUT, which only matters when no ack arrives in that cycle.
    always_comb begin
        cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
        tmo   = (TIMEOUT != 0) && (cnt_d == TMAX);
        hs    = (state_q == HOLD) & instr_ready & ~Disable & ~flush;
    end

    assign inc         = hs;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!Disable && !flush) begin
                        if (pc_val[1:0] != 2'b00) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= ERR;
                        end else begin
                            mem_addr_q <= pc_val;
                            mem_req_q  <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            instr_q       <= mem_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end else if (tmo) begin
                        cnt_q       <= cnt_d;
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= ERR;
                    end else begin
                        cnt_q <= cnt_d;
                        if (flush) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Request stays up until the bus answers; data dropped.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (tmo) begin
                        cnt_q       <= cnt_d;
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= ERR;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (flush || hs) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                ERR: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    if (flush) begin
                        fetch_err_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: normal fetch, backpressure, flushes,
// timeout, misaligned PC and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] pc_val;
    logic        Disable;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        inc;
    logic        fetch_err;

    int nvec = 0;
    int nerr = 0;

    fetch_unit dut (
        .clk        (clk),
        .clr        (clr),
        .pc_val     (pc_val),
        .Disable    (Disable),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .inc        (inc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req"}, 32'(mem_req), 32'd0);
        chk({tag, " addr"}, mem_addr, 32'd0);
        chk({tag, " instr"}, instr, 32'd0);
        chk({tag, " valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " err"}, 32'(fetch_err), 32'd0);
        chk({tag, " inc"}, 32'(inc), 32'd0);
    endtask

    initial begin
        clr = 1'b0;
        pc_val = 32'h0;
        Disable = 1'b0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        instr_ready = 1'b1;
        #12;
        chk_zero("rst");

        // 1: basic fetch, ack in second request cycle
        tick;
        clr = 1'b1;
        #1 chk("t1 req pre", 32'(mem_req), 32'd0);
        tick;
        chk("t1 req", 32'(mem_req), 32'd1);
        chk("t1 addr", mem_addr, 32'h0);
        tick;
        chk("t1 req w", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h00500093;
        tick;
        mem_ack = 1'b0;
        #1;
        chk("t1 instr", instr, 32'h00500093);
        chk("t1 valid", 32'(instr_valid), 32'd1);
        chk("t1 req off", 32'(mem_req), 32'd0);
        chk("t1 inc", 32'(inc), 32'd1);
        tick;
        chk("t1 inc off", 32'(inc), 32'd0);
        chk("t1 valid off", 32'(instr_valid), 32'd0);
        pc_val = 32'h4;
        tick;
        chk("t1 addr4", mem_addr, 32'h4);
        chk("t1 req4", 32'(mem_req), 32'd1);

        // 2: instr_ready backpressure
        mem_ack = 1'b1;
        mem_rdata = 32'h11111113;
        instr_ready = 1'b0;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2 instr", instr, 32'h11111113);
            chk("t2 valid", 32'(instr_valid), 32'd1);
            chk("t2 inc", 32'(inc), 32'd0);
            if (i < 2) tick;
        end
        instr_ready = 1'b1;
        #1 chk("t2 inc on", 32'(inc), 32'd1);
        tick;
        chk("t2 inc once", 32'(inc), 32'd0);
        chk("t2 valid off", 32'(instr_valid), 32'd0);
        pc_val = 32'h8;
        tick;
        chk("t2 addr8", mem_addr, 32'h8);

        // 2b: Disable stall while instr_ready=1
        mem_ack = 1'b1;
        mem_rdata = 32'h22222213;
        Disable = 1'b1;
        tick;
        mem_ack = 1'b0;
        #1;
        chk("t2d valid", 32'(instr_valid), 32'd1);
        chk("t2d inc", 32'(inc), 32'd0);
        tick;
        chk("t2d inc2", 32'(inc), 32'd0);
        chk("t2d instr", instr, 32'h22222213);
        Disable = 1'b0;
        #1 chk("t2d inc on", 32'(inc), 32'd1);
        tick;
        pc_val = 32'hC;
        tick;
        chk("t3 addrC", mem_addr, 32'hC);

        // 3: flush in first request cycle, ack two cycles later
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        chk("t3 req drain", 32'(mem_req), 32'd1);
        chk("t3 inc", 32'(inc), 32'd0);
        tick;
        chk("t3 req drain2", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ack = 1'b0;
        pc_val = 32'h40;
        #1;
        chk("t3 req off", 32'(mem_req), 32'd0);
        chk("t3 valid", 32'(instr_valid), 32'd0);
        chk("t3 inc2", 32'(inc), 32'd0);
        tick;
        chk("t3 addr40", mem_addr, 32'h40);
        chk("t3 req40", 32'(mem_req), 32'd1);

        // 4: flush coincident with ack
        mem_ack = 1'b1;
        flush = 1'b1;
        tick;
        mem_ack = 1'b0;
        flush = 1'b0;
        #1;
        chk("t4 valid", 32'(instr_valid), 32'd0);
        chk("t4 req", 32'(mem_req), 32'd0);
        chk("t4 instr kept", instr, 32'h22222213);
        tick;
        chk("t4 refetch", 32'(mem_req), 32'd1);

        // 5: timeout after 15 cycles of request without ack
        for (int i = 0; i < 14; i++) begin
            tick;
            chk("t5 req wait", 32'(mem_req), 32'd1);
        end
        chk("t5 err pre", 32'(fetch_err), 32'd0);
        tick;
        chk("t5 req drop", 32'(mem_req), 32'd0);
        chk("t5 err", 32'(fetch_err), 32'd1);
        tick;
        chk("t5 err sticky", 32'(fetch_err), 32'd1);
        chk("t5 req idle", 32'(mem_req), 32'd0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1 chk("t5 err clr", 32'(fetch_err), 32'd0);
        tick;
        chk("t5 req new", 32'(mem_req), 32'd1);
        chk("t5 addr new", mem_addr, 32'h40);
        mem_ack = 1'b1;
        mem_rdata = 32'h33333313;
        tick;
        mem_ack = 1'b0;
        #1 chk("t5 inc", 32'(inc), 32'd1);
        tick;

        // 6: misaligned PC, then async reset mid-request
        pc_val = 32'h22;
        tick;
        chk("t6 err", 32'(fetch_err), 32'd1);
        chk("t6 req", 32'(mem_req), 32'd0);
        tick;
        chk("t6 req2", 32'(mem_req), 32'd0);
        pc_val = 32'h30;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tick;
        chk("t6 req30", 32'(mem_req), 32'd1);
        chk("t6 addr30", mem_addr, 32'h30);
        #2 clr = 1'b0;
        #1 chk_zero("t6 async");
        tick;
        chk_zero("t6 held");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
